exception_unit: RTL and testbench
=================================

EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2 (range 1..7): number of cycles flush is held after a report.
REQ-002 SHALL have port clk  input  1  system clock; one clock, all state on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  pipeline stall; freezes carry registers.
REQ-005 SHALL have port pipe_flush  input  1  branch/jump flush; kills ID and EX entries.
REQ-006 SHALL have ports id_valid, ex_valid, mem_valid  input  1 each  stage holds a real instruction.
REQ-007 SHALL have ports id_ri, id_syscall  input  1 each  reserved-instruction and syscall detected in ID.
REQ-008 SHALL have ports ex_ovf, ex_tr  input  1 each  overflow and trap detected in EX.
REQ-009 SHALL have ports mem_addrl, mem_addrs  input  1 each  misaligned load and misaligned store detected in MEM.
REQ-010 SHALL have port mem_pc  input  32  PC of the instruction in MEM.
REQ-011 SHALL have port mem_addr  input  32  data address of the instruction in MEM.
REQ-012 SHALL have port exception_bus  output  70  registered report: [69:64] one-hot cause (EXC_OFF_* offsets), [63:32] EPC, [31:0] BadVA.
REQ-013 SHALL have port flush  output  1  kill all stages IF..MEM.
REQ-014 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-015 SHALL carry ID flags in an ID->EX register and ID+EX flags in an EX->MEM register, with flags travelling alongside their instruction.
REQ-016 SHALL hold both carry registers unchanged while stall=1.
REQ-017 SHALL clear both carry registers when pipe_flush=1; pipe_flush takes precedence over stall.
REQ-018 SHALL ignore flag inputs of any stage whose valid=0.
REQ-019 SHALL evaluate only the MEM instruction (carried flags OR MEM flags) so reporting is precise and in program order.
REQ-020 SHALL prioritise cause as RI > SYSCALL > OVF > TR > ADDRL > ADDRS, and SHALL set exactly one cause bit.
REQ-021 SHALL implement an FSM with states IDLE -> REPORT -> FLUSH -> IDLE.
REQ-022 IDLE: SHALL move to REPORT on the next edge when an exception is present in MEM and stall=0; with stall=1, SHALL wait.
REQ-023 REPORT: SHALL drive exception_bus non-zero for exactly one cycle, with EPC=mem_pc and BadVA as defined in REQ-031/032; latency is 1 cycle after detection in MEM.
REQ-024 REPORT: SHALL assert flush and SHALL clear both carry registers.
REQ-025 FLUSH: SHALL keep exception_bus=0 and flush=1 for FLUSH_CYCLES-1 further cycles, then return to IDLE.
REQ-026 SHALL ignore all inputs in REPORT and FLUSH, and SHALL not queue a second exception.
REQ-027 exception_bus SHALL be 0 in every cycle other than REPORT.

Reset
REQ-028 On reset, SHALL set state=IDLE and clear exception_bus, flush, busy and both carry registers.
REQ-029 Reset mid-REPORT or mid-FLUSH SHALL abort the sequence, with no report emitted on the following cycle.

Configuration
REQ-030 SHALL support macro EXC_BADVA_EN.
REQ-031 With EXC_BADVA_EN defined, BadVA SHALL be mem_addr for ADDRL/ADDRS and 0 for other causes.
REQ-032 Without EXC_BADVA_EN, BadVA SHALL always be 0 and mem_addr SHALL be unused.

Structure
REQ-033 The shared defines file SHALL hold the EXC_OFF_* bit offsets, the bus field widths and the FSM state encodings.
REQ-034 The carry register SHALL be sub-module exc_stage_reg (flags in/out, stall, clear), instantiated twice.

Verification
REQ-035 ADDRL in MEM, mem_pc=0x00400010, mem_addr=0x10010003 -> next cycle bus cause=ADDRL, EPC=0x00400010, BadVA=0x10010003 (0 without EXC_BADVA_EN); flush high 2 cycles.
REQ-036 id_ri on an instruction at 0x00400008, no stalls -> report exactly 3 cycles later with cause=RI, EPC=0x00400008.
REQ-037 SYSCALL instruction in EX and ADDRS on older instruction in MEM in the same cycle -> only ADDRS reported; SYSCALL entry flushed, never reported.
REQ-038 pipe_flush in the cycle id_syscall is set -> no report ever issued.
REQ-039 Exception in MEM with stall=1 for 3 cycles -> report only after stall drops; during FLUSH, ex_ovf pulse ignored.
REQ-040 Reset asserted in REPORT cycle -> bus, flush and busy all 0 on the next cycle.

Source files
------------

// File: rtl/exception_unit_pkg.sv
// Shared definitions for the exception unit: cause offsets, bus layout, FSM states.
// Cause offsets are ordered so that a higher bit index means a higher priority.
package exception_unit_pkg;

    localparam int unsigned CAUSE_W = 6;
    localparam int unsigned EPC_W   = 32;
    localparam int unsigned BADVA_W = 32;
    localparam int unsigned BUS_W   = CAUSE_W + EPC_W + BADVA_W;
    localparam int unsigned CNT_W   = 3;

    localparam int unsigned EXC_OFF_ADDRS   = 0;
    localparam int unsigned EXC_OFF_ADDRL   = 1;
    localparam int unsigned EXC_OFF_TR      = 2;
    localparam int unsigned EXC_OFF_OVF     = 3;
    localparam int unsigned EXC_OFF_SYSCALL = 4;
    localparam int unsigned EXC_OFF_RI      = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPORT = 2'd1,
        ST_FLUSH  = 2'd2
    } exc_state_e;

    typedef struct packed {
        logic [CAUSE_W-1:0] cause;
        logic [EPC_W-1:0]   epc;
        logic [BADVA_W-1:0] badva;
    } exc_bus_t;

    // One-hot of the highest-priority pending flag.
    function automatic logic [CAUSE_W-1:0] prio_cause(input logic [CAUSE_W-1:0] flags);
        prio_cause = '0;
        for (int i = 0; i < int'(CAUSE_W); i++) begin
            if (flags[i]) prio_cause = CAUSE_W'(1) << i;
        end
    endfunction

endpackage

// File: rtl/exc_stage_reg.sv
// Pipeline carry register for exception flags; clear wins over stall.
module exc_stage_reg #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         clear,
    input  logic [W-1:0] flags_i,
    output logic [W-1:0] flags_o
);

    logic [W-1:0] flags_q;

    always_ff @(posedge clk) begin
        if (reset || clear) flags_q <= '0;
        else if (!stall)    flags_q <= flags_i;
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/exception_unit.sv
// Precise exception reporting for a 5-stage pipeline; flags ride with instructions to MEM.
// Optional macro EXC_BADVA_EN fills BadVA with mem_addr for address-error causes.
module exception_unit
    import exception_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pipe_flush,
    input  logic             id_valid,
    input  logic             ex_valid,
    input  logic             mem_valid,
    input  logic             id_ri,
    input  logic             id_syscall,
    input  logic             ex_ovf,
    input  logic             ex_tr,
    input  logic             mem_addrl,
    input  logic             mem_addrs,
    input  logic [EPC_W-1:0] mem_pc,
    input  logic [31:0]      mem_addr,
    output logic [BUS_W-1:0] exception_bus,
    output logic             flush,
    output logic             busy
);

    exc_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    exc_bus_t           bus_q, bus_d;
    logic               flush_q, flush_d;
    logic               busy_q, busy_d;

    logic [CAUSE_W-1:0] id_flags, ex_flags, mem_flags;
    logic [CAUSE_W-1:0] id_ex_q, ex_mem_q;
    logic               carry_clear;
    logic               exc_present;
    exc_bus_t           report;

    // Flags of each stage's own detection, gated by that stage's valid.
    always_comb begin
        id_flags  = '0;
        ex_flags  = '0;
        mem_flags = '0;
        id_flags[EXC_OFF_RI]      = id_ri;
        id_flags[EXC_OFF_SYSCALL] = id_syscall;
        if (!id_valid) id_flags = '0;
        ex_flags = id_ex_q;
        ex_flags[EXC_OFF_OVF] = id_ex_q[EXC_OFF_OVF] | ex_ovf;
        ex_flags[EXC_OFF_TR]  = id_ex_q[EXC_OFF_TR]  | ex_tr;
        if (!ex_valid) ex_flags = '0;
        mem_flags = ex_mem_q;
        mem_flags[EXC_OFF_ADDRL] = ex_mem_q[EXC_OFF_ADDRL] | mem_addrl;
        mem_flags[EXC_OFF_ADDRS] = ex_mem_q[EXC_OFF_ADDRS] | mem_addrs;
        if (!mem_valid) mem_flags = '0;
    end

    assign carry_clear = pipe_flush || (state_q != ST_IDLE);
    assign exc_present = |mem_flags;

    exc_stage_reg #(.W(CAUSE_W)) u_id_ex (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .clear   (carry_clear),
        .flags_i (id_flags),
        .flags_o (id_ex_q)
    );

    exc_stage_reg #(.W(CAUSE_W)) u_ex_mem (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .clear   (carry_clear),
        .flags_i (ex_flags),
        .flags_o (ex_mem_q)
    );

    // Report payload for the instruction currently in MEM.
    always_comb begin
        report       = '0;
        report.cause = prio_cause(mem_flags);
        report.epc   = mem_pc;
`ifdef EXC_BADVA_EN
        if (report.cause[EXC_OFF_ADDRL] || report.cause[EXC_OFF_ADDRS]) report.badva = mem_addr;
`endif
    end

`ifndef EXC_BADVA_EN
    logic unused_mem_addr;
    assign unused_mem_addr = ^mem_addr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_present && !stall) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                cnt_d = CNT_W'(1);
                if (FLUSH_CYCLES > 1) state_d = ST_FLUSH;
                else                  state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (cnt_q >= CNT_W'(FLUSH_CYCLES - 1)) state_d = ST_IDLE;
                else                                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs follow the state being entered so they register in step with it.
    always_comb begin
        bus_d   = '0;
        flush_d = 1'b0;
        busy_d  = 1'b0;
        case (state_d)
            ST_REPORT: begin
                bus_d   = report;
                flush_d = 1'b1;
                busy_d  = 1'b1;
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                busy_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q   <= '0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            bus_q   <= bus_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
        end
    end

    assign exception_bus = bus_q;
    assign flush         = flush_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: directed scenarios plus randomized traffic vs. a pipeline model.
module tb_exception_unit;
    import exception_unit_pkg::*;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        reset, stall, pipe_flush;
    logic        id_valid, ex_valid, mem_valid;
    logic        id_ri, id_syscall, ex_ovf, ex_tr, mem_addrl, mem_addrs;
    logic [31:0] mem_pc, mem_addr;
    logic [69:0] exception_bus;
    logic        flush, busy;

    always #5 clk = ~clk;

    exception_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pipe_flush    (pipe_flush),
        .id_valid      (id_valid),
        .ex_valid      (ex_valid),
        .mem_valid     (mem_valid),
        .id_ri         (id_ri),
        .id_syscall    (id_syscall),
        .ex_ovf        (ex_ovf),
        .ex_tr         (ex_tr),
        .mem_addrl     (mem_addrl),
        .mem_addrs     (mem_addrs),
        .mem_pc        (mem_pc),
        .mem_addr      (mem_addr),
        .exception_bus (exception_bus),
        .flush         (flush),
        .busy          (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Model: exception sets carried by the instructions in EX and MEM, and flush cycles remaining.
    logic [5:0]  m_ex = '0, m_mem = '0;
    int          m_left = 0;
    logic [69:0] exp_bus = '0;
    logic        exp_flush = 1'b0, exp_busy = 1'b0;

    function automatic logic [5:0] top_cause(input logic [5:0] f);
        int order[6] = '{EXC_OFF_RI, EXC_OFF_SYSCALL, EXC_OFF_OVF, EXC_OFF_TR, EXC_OFF_ADDRL, EXC_OFF_ADDRS};
        for (int i = 0; i < 6; i++) begin
            if (f[order[i]]) return 6'(1) << order[i];
        end
        return 6'd0;
    endfunction

    function automatic logic [31:0] exp_badva(input logic [5:0] c, input logic [31:0] a);
`ifdef EXC_BADVA_EN
        if (c[EXC_OFF_ADDRL] || c[EXC_OFF_ADDRS]) return a;
`endif
        return (a & 32'd0) | (32'(c) & 32'd0);
    endfunction

    function automatic logic [69:0] mk_bus(input int off, input logic [31:0] pc, input logic [31:0] a);
        logic [5:0] c;
        c = 6'(1) << off;
        return {c, pc, exp_badva(c, a)};
    endfunction

    task automatic quiet();
        stall = 0; pipe_flush = 0;
        id_valid = 1; ex_valid = 1; mem_valid = 1;
        id_ri = 0; id_syscall = 0; ex_ovf = 0; ex_tr = 0; mem_addrl = 0; mem_addrs = 0;
        mem_pc = 32'h0; mem_addr = 32'h0;
    endtask

    // Advance the model on the current inputs, then clock the DUT and settle.
    task automatic tick();
        logic [5:0] id_own, ex_own, mem_own, mem_all, c;
        id_own = '0; ex_own = '0; mem_own = '0;
        id_own[EXC_OFF_RI] = id_ri;       id_own[EXC_OFF_SYSCALL] = id_syscall;
        ex_own[EXC_OFF_OVF] = ex_ovf;     ex_own[EXC_OFF_TR] = ex_tr;
        mem_own[EXC_OFF_ADDRL] = mem_addrl; mem_own[EXC_OFF_ADDRS] = mem_addrs;
        exp_bus = '0;
        exp_flush = 1'b0;
        if (reset) begin
            m_ex = '0; m_mem = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_ex = '0; m_mem = '0;
            exp_flush = (m_left > 0);
        end else begin
            mem_all = mem_valid ? (m_mem | mem_own) : 6'd0;
            if (mem_all != 6'd0 && !stall) begin
                c = top_cause(mem_all);
                exp_bus = {c, mem_pc, exp_badva(c, mem_addr)};
                m_left = int'(FC);
                exp_flush = 1'b1;
            end
            if (pipe_flush) begin
                m_ex = '0; m_mem = '0;
            end else if (!stall) begin
                m_mem = ex_valid ? (m_ex | ex_own) : 6'd0;
                m_ex  = id_valid ? id_own : 6'd0;
            end
        end
        exp_busy = (m_left > 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1; mem_addrl = 1; mem_pc = 32'h00400000;
        tick(); tick();
        checks++; if (exception_bus !== 70'd0) begin failures++; $display("FAIL reset_bus: got %h want 0", exception_bus); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        quiet(); reset = 0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_addrl();
        logic [69:0] want;
        quiet();
        mem_addrl = 1; mem_pc = 32'h00400010; mem_addr = 32'h10010003;
        want = mk_bus(EXC_OFF_ADDRL, 32'h00400010, 32'h10010003);
        tick();
        checks++; if (exception_bus !== want) begin failures++; $display("FAIL addrl_bus: got %h want %h", exception_bus, want); end
        checks++; if (flush !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL addrl_flush1: got flush=%b busy=%b want 1/1", flush, busy); end
        quiet();
        tick();
        checks++; if (exception_bus !== 70'd0 || flush !== 1'b1) begin failures++; $display("FAIL addrl_flush2: got bus=%h flush=%b want 0/1", exception_bus, flush); end
        tick();
        checks++; if (flush !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL addrl_done: got flush=%b busy=%b want 0/0", flush, busy); end
    endtask

    task automatic test_ri_latency();
        logic [69:0] want;
        quiet();
        id_ri = 1;
        tick();
        id_ri = 0;
        checks++; if (exception_bus !== 70'd0) begin failures++; $display("FAIL ri_early1: got %h want 0", exception_bus); end
        tick();
        checks++; if (exception_bus !== 70'd0) begin failures++; $display("FAIL ri_early2: got %h want 0", exception_bus); end
        mem_pc = 32'h00400008;
        want = mk_bus(EXC_OFF_RI, 32'h00400008, 32'h0);
        tick();
        checks++; if (exception_bus !== want) begin failures++; $display("FAIL ri_report: got %h want %h", exception_bus, want); end
        quiet();
        for (int i = 0; i < int'(FC) + 1; i++) tick();
    endtask

    task automatic test_precise();
        logic [69:0] want;
        quiet();
        id_syscall = 1;
        tick();
        quiet();
        mem_addrs = 1; mem_pc = 32'h00400020; mem_addr = 32'h10010006;
        want = mk_bus(EXC_OFF_ADDRS, 32'h00400020, 32'h10010006);
        tick();
        checks++; if (exception_bus !== want) begin failures++; $display("FAIL precise_addrs: got %h want %h", exception_bus, want); end
        quiet();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (exception_bus !== 70'd0) begin failures++; $display("FAIL precise_no_syscall: cycle %0d got %h want 0", i, exception_bus); end
        end
    endtask

    task automatic test_pipe_flush();
        quiet();
        id_syscall = 1; pipe_flush = 1;
        tick();
        quiet();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (exception_bus !== 70'd0 || busy !== 1'b0) begin failures++; $display("FAIL pipe_flush_kill: cycle %0d got bus=%h busy=%b want 0/0", i, exception_bus, busy); end
        end
    endtask

    task automatic test_stall();
        logic [69:0] want;
        quiet();
        mem_addrl = 1; mem_pc = 32'h00400030; mem_addr = 32'h10010001; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (exception_bus !== 70'd0 || busy !== 1'b0) begin failures++; $display("FAIL stall_wait: cycle %0d got bus=%h busy=%b want 0/0", i, exception_bus, busy); end
        end
        stall = 0;
        want = mk_bus(EXC_OFF_ADDRL, 32'h00400030, 32'h10010001);
        tick();
        checks++; if (exception_bus !== want) begin failures++; $display("FAIL stall_report: got %h want %h", exception_bus, want); end
        quiet();
        tick();
        checks++; if (flush !== 1'b1 || exception_bus !== 70'd0) begin failures++; $display("FAIL stall_flush: got flush=%b bus=%h want 1/0", flush, exception_bus); end
        ex_ovf = 1;
        tick();
        ex_ovf = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (exception_bus !== 70'd0) begin failures++; $display("FAIL stall_ovf_ignored: cycle %0d got %h want 0", i, exception_bus); end
        end
    endtask

    task automatic test_reset_in_report();
        quiet();
        mem_addrs = 1; mem_pc = 32'h00400040; mem_addr = 32'h10010002;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_rep_enter: got busy=%b want 1", busy); end
        reset = 1;
        tick();
        checks++; if (exception_bus !== 70'd0 || flush !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_rep_abort: got bus=%h flush=%b busy=%b want 0/0/0", exception_bus, flush, busy); end
        reset = 0; quiet();
        tick();
        checks++; if (exception_bus !== 70'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_rep_after: got bus=%h busy=%b want 0/0", exception_bus, busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            reset      = ($urandom_range(0, 99) < 2);
            stall      = ($urandom_range(0, 99) < 20);
            pipe_flush = ($urandom_range(0, 99) < 10);
            id_valid   = ($urandom_range(0, 99) < 85);
            ex_valid   = ($urandom_range(0, 99) < 85);
            mem_valid  = ($urandom_range(0, 99) < 85);
            id_ri      = ($urandom_range(0, 15) == 0);
            id_syscall = ($urandom_range(0, 15) == 0);
            ex_ovf     = ($urandom_range(0, 15) == 0);
            ex_tr      = ($urandom_range(0, 15) == 0);
            mem_addrl  = ($urandom_range(0, 15) == 0);
            mem_addrs  = ($urandom_range(0, 15) == 0);
            mem_pc     = $urandom;
            mem_addr   = $urandom;
            tick();
            checks++; if (exception_bus !== exp_bus) begin failures++; $display("FAIL rand_bus: cycle %0d got %h want %h", n, exception_bus, exp_bus); end
            checks++; if (flush !== exp_flush) begin failures++; $display("FAIL rand_flush: cycle %0d got %b want %b", n, flush, exp_flush); end
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL rand_busy: cycle %0d got %b want %b", n, busy, exp_busy); end
        end
    endtask

    initial begin
        quiet();
        reset = 1;
        test_reset();
        test_addrl();
        test_ri_latency();
        test_precise();
        test_pipe_flush();
        test_stall();
        test_reset_in_report();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
